// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and instruction fetch sequencer
//
// Computes the next PC and runs the fetch handshake with instruction memory.
// The next PC is one of: PC+1, a PC-relative branch, or an absolute jump.
// The condition FSM decides which one, and this block applies it.
//
// Ports:
//   clka           clock; all state changes on posedge
//   reset_in       synchronous active-low reset
//   pc_latch_in    PC-update strobe (level; rising edge = one update)
//   pc_ctl_0_in    branch taken: PC <= NPC + sext(offset_in)
//   offset_in      signed PC-relative branch offset
//   jmp_in         absolute jump request (beats a branch)
//   jmp_target_in  absolute jump target
//   halt_in        enter HALT instead of updating the PC
//   imem_ready_in  insmem accepted the address on pc_out
//   pc_out         current PC / insmem address
//   npc_out        pc_out + 1 (registered alongside pc_out)
//   imem_req_out   fetch request; pc_out is stable while high
//   pc_valid_out   instruction at pc_out has been fetched
//   state_out      BOOT=00 FETCH=01 EXEC=10 HALT=11
module pc_sequencer #(
    parameter int              PC_W     = 16,
    parameter int              OFF_W    = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clka,
    input  logic             reset_in,
    input  logic             pc_latch_in,
    input  logic             pc_ctl_0_in,
    input  logic [OFF_W-1:0] offset_in,
    input  logic             jmp_in,
    input  logic [PC_W-1:0]  jmp_target_in,
    input  logic             halt_in,
    input  logic             imem_ready_in,
    output logic [PC_W-1:0]  pc_out,
    output logic [PC_W-1:0]  npc_out,
    output logic             imem_req_out,
    output logic             pc_valid_out,
    output logic [1:0]       state_out
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] npc_q;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic            latch_prev_q;
    logic            pend_q, pend_d;

    logic            upd;
    logic [PC_W-1:0] offset_ext;
    logic [PC_W-1:0] branch_pc;

    // A held strobe level produces exactly one update on its rising edge.
    assign upd        = pc_latch_in & ~latch_prev_q;
    assign offset_ext = {{(PC_W-OFF_W){offset_in[OFF_W-1]}}, offset_in};
    assign branch_pc  = npc_q + offset_ext;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        valid_d = valid_q;
        pend_d  = pend_q;

        case (state_q)
            ST_BOOT: begin
                // No update is applied here, so instruction RESET_PC is
                // fetched first. A strobe that arrives now is remembered.
                if (upd) pend_d = 1'b1;
                state_d = ST_FETCH;
                req_d   = 1'b1;
            end
            ST_FETCH: begin
                // An update cannot move pc_out while it is on the insmem bus.
                // Defer it until the fetch completes.
                if (upd) pend_d = 1'b1;
                if (imem_ready_in) begin
                    state_d = ST_EXEC;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                end
            end
            ST_EXEC: begin
                if (upd || pend_q) begin
                    pend_d  = 1'b0;
                    valid_d = 1'b0;
                    if (halt_in) begin
                        state_d = ST_HALT;
                        req_d   = 1'b0;
                    end else begin
                        if (jmp_in)           pc_d = jmp_target_in;
                        else if (pc_ctl_0_in) pc_d = branch_pc;
                        else                  pc_d = npc_q;
                        state_d = ST_FETCH;
                        req_d   = 1'b1;
                    end
                end
            end
            default: begin
                // HALT is absorbing; only reset leaves it.
                state_d = ST_HALT;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clka) begin
        if (!reset_in) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            npc_q        <= RESET_PC + PC_ONE;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            latch_prev_q <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            npc_q        <= pc_d + PC_ONE;
            req_q        <= req_d;
            valid_q      <= valid_d;
            latch_prev_q <= pc_latch_in;
            pend_q       <= pend_d;
        end
    end

    assign pc_out       = pc_q;
    assign npc_out      = npc_q;
    assign imem_req_out = req_q;
    assign pc_valid_out = valid_q;
    assign state_out    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clka = 1'b0;
    logic        reset_in = 1'b0;
    logic        pc_latch_in = 1'b0;
    logic        pc_ctl_0_in = 1'b0;
    logic [8:0]  offset_in = '0;
    logic        jmp_in = 1'b0;
    logic [15:0] jmp_target_in = '0;
    logic        halt_in = 1'b0;
    logic        imem_ready_in = 1'b1;
    logic [15:0] pc_out;
    logic [15:0] npc_out;
    logic        imem_req_out;
    logic        pc_valid_out;
    logic [1:0]  state_out;

    pc_sequencer #(.PC_W(16), .OFF_W(9), .RESET_PC(16'h0000)) dut (
        .clka          (clka),
        .reset_in      (reset_in),
        .pc_latch_in   (pc_latch_in),
        .pc_ctl_0_in   (pc_ctl_0_in),
        .offset_in     (offset_in),
        .jmp_in        (jmp_in),
        .jmp_target_in (jmp_target_in),
        .halt_in       (halt_in),
        .imem_ready_in (imem_ready_in),
        .pc_out        (pc_out),
        .npc_out       (npc_out),
        .imem_req_out  (imem_req_out),
        .pc_valid_out  (pc_valid_out),
        .state_out     (state_out)
    );

    always #5 clka = ~clka;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: the phase of the fetch/execute cycle, the PC as a
    // number, and the deferred-update / strobe-history flags.
    localparam int P_BOOT = 0, P_FETCH = 1, P_EXEC = 2, P_HALT = 3;
    int          m_phase;
    int          m_pc;
    bit          m_req, m_val, m_prev, m_pend;

    logic [35:0] dut_vec;
    assign dut_vec = {state_out, pc_out, npc_out, imem_req_out, pc_valid_out};

    function automatic logic [35:0] exp_vec();
        logic [15:0] p, n;
        p = 16'(m_pc % 65536);
        n = 16'((m_pc + 1) % 65536);
        return {2'(m_phase), p, n, m_req, m_val};
    endfunction

    task automatic model_step();
        bit strobe;
        int off;
        if (!reset_in) begin
            m_phase = P_BOOT; m_pc = 0; m_req = 0; m_val = 0;
            m_prev = 0; m_pend = 0;
            return;
        end
        strobe = pc_latch_in && !m_prev;
        m_prev = pc_latch_in;
        if (m_phase == P_BOOT) begin
            if (strobe) m_pend = 1;
            m_phase = P_FETCH; m_req = 1;
        end else if (m_phase == P_FETCH) begin
            if (strobe) m_pend = 1;
            if (imem_ready_in) begin m_phase = P_EXEC; m_req = 0; m_val = 1; end
        end else if (m_phase == P_EXEC && (strobe || m_pend)) begin
            m_pend = 0; m_val = 0;
            if (halt_in) begin
                m_phase = P_HALT; m_req = 0;
            end else begin
                off = int'(offset_in);
                if (off >= 256) off = off - 512;
                if (jmp_in)           m_pc = int'(jmp_target_in);
                else if (pc_ctl_0_in) m_pc = (m_pc + 1 + off + 65536) % 65536;
                else                  m_pc = (m_pc + 1) % 65536;
                m_phase = P_FETCH; m_req = 1;
            end
        end
    endtask

    // Advance one clock, then update the model with the inputs that were
    // present at that edge; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clka);
        #1;
        cyc++;
        model_step();
    endtask

    // Drive a jump from EXEC to a known PC and return to EXEC (ready=1).
    task automatic go_to(input logic [15:0] tgt);
        imem_ready_in = 1; jmp_in = 1; jmp_target_in = tgt; pc_latch_in = 1;
        tick();
        jmp_in = 0; pc_latch_in = 0;
        tick();
    endtask

    task automatic test_reset();
        reset_in = 0; imem_ready_in = 1;
        tick(); tick();
        n_tests++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL reset_model cycle %0d: got %h expected %h", cyc, dut_vec, exp_vec());
        end
        n_tests++;
        if (dut_vec !== {2'b00, 16'h0000, 16'h0001, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL reset_values: got %h expected %h", dut_vec, {2'b00, 16'h0000, 16'h0001, 2'b00});
        end
    endtask

    task automatic test_sequential();
        reset_in = 1; imem_ready_in = 1;
        for (int i = 0; i < 8; i++) begin
            pc_latch_in = (i >= 2) && (i % 2 == 0);
            tick();
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL sequential cycle %0d: got %h expected %h", cyc, dut_vec, exp_vec());
            end
            if (state_out == 2'b10 && pc_valid_out !== 1'b1) begin
                n_fail++; $display("FAIL valid_in_exec: got %b expected 1", pc_valid_out);
            end
        end
        pc_latch_in = 0;
        tick();
        n_tests++;
        if (pc_out !== 16'h0003 || state_out !== 2'b10) begin
            n_fail++; $display("FAIL sequential_end: got pc %h st %b expected pc 0003 st 10", pc_out, state_out);
        end
    endtask

    task automatic test_branch();
        go_to(16'h0010);
        pc_ctl_0_in = 1; offset_in = 9'h1F0; pc_latch_in = 1;
        tick();
        n_tests++;
        if (pc_out !== 16'h0001 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL branch_neg: got %h expected pc 0001 vec %h", dut_vec, exp_vec());
        end
        pc_ctl_0_in = 0; pc_latch_in = 0;
        tick();
        go_to(16'h0010);
        pc_ctl_0_in = 1; offset_in = 9'h005; pc_latch_in = 1;
        tick();
        n_tests++;
        if (pc_out !== 16'h0016 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL branch_pos: got %h expected pc 0016 vec %h", dut_vec, exp_vec());
        end
        pc_ctl_0_in = 0; pc_latch_in = 0;
        tick();
    endtask

    task automatic test_jump_priority();
        jmp_in = 1; jmp_target_in = 16'h4000; pc_ctl_0_in = 1; offset_in = 9'h005;
        pc_latch_in = 1;
        tick();
        n_tests++;
        if (pc_out !== 16'h4000) begin
            n_fail++; $display("FAIL jump_priority: got pc %h expected 4000", pc_out);
        end
        jmp_in = 0; pc_ctl_0_in = 0; pc_latch_in = 0;
        tick();
        pc_latch_in = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL held_strobe cycle %0d: got %h expected %h", cyc, dut_vec, exp_vec());
            end
        end
        n_tests++;
        if (pc_out !== 16'h4001 || state_out !== 2'b10) begin
            n_fail++; $display("FAIL held_strobe_once: got pc %h st %b expected 4001 10", pc_out, state_out);
        end
        pc_latch_in = 0;
        tick();
    endtask

    task automatic test_fetch_stall();
        pc_latch_in = 1;
        tick();
        pc_latch_in = 0; imem_ready_in = 0;
        for (int i = 0; i < 4; i++) begin
            pc_latch_in = (i == 1);
            tick();
            n_tests++;
            if (pc_out !== 16'h4002 || imem_req_out !== 1'b1 || state_out !== 2'b01) begin
                n_fail++; $display("FAIL stall cycle %0d: got pc %h req %b st %b expected 4002 1 01", cyc, pc_out, imem_req_out, state_out);
            end
        end
        pc_latch_in = 0; imem_ready_in = 1;
        tick();
        n_tests++;
        if (state_out !== 2'b10 || pc_valid_out !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL stall_release: got %h expected %h", dut_vec, exp_vec());
        end
        tick();
        n_tests++;
        if (pc_out !== 16'h4003 || state_out !== 2'b01) begin
            n_fail++; $display("FAIL pend_apply: got pc %h st %b expected 4003 01", pc_out, state_out);
        end
        tick();
    endtask

    task automatic test_wrap_and_reset();
        go_to(16'hFFFF);
        n_tests++;
        if (npc_out !== 16'h0000) begin
            n_fail++; $display("FAIL npc_wrap: got %h expected 0000", npc_out);
        end
        pc_latch_in = 1;
        tick();
        n_tests++;
        if (pc_out !== 16'h0000 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL pc_wrap: got %h expected %h", dut_vec, exp_vec());
        end
        pc_latch_in = 0;
        tick();
        jmp_in = 1; jmp_target_in = 16'h1234; pc_latch_in = 1;
        tick();
        jmp_in = 0; pc_latch_in = 0; imem_ready_in = 0;
        tick();
        reset_in = 0;
        tick();
        n_tests++;
        if (pc_out !== 16'h0000 || imem_req_out !== 1'b0 || state_out !== 2'b00) begin
            n_fail++; $display("FAIL reset_mid_fetch: got pc %h req %b st %b expected 0000 0 00", pc_out, imem_req_out, state_out);
        end
        reset_in = 1; imem_ready_in = 1;
    endtask

    task automatic test_halt();
        tick(); tick();
        halt_in = 1; pc_latch_in = 1;
        tick();
        n_tests++;
        if (state_out !== 2'b11 || imem_req_out !== 1'b0 || pc_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL halt_enter: got st %b req %b val %b expected 11 0 0", state_out, imem_req_out, pc_valid_out);
        end
        halt_in = 0;
        for (int i = 0; i < 6; i++) begin
            pc_latch_in = i[0]; jmp_in = 1; jmp_target_in = 16'h0BAD;
            tick();
            n_tests++;
            if (dut_vec !== exp_vec() || pc_out !== 16'h0000) begin
                n_fail++; $display("FAIL halt_hold cycle %0d: got %h expected %h", cyc, dut_vec, exp_vec());
            end
        end
        jmp_in = 0; pc_latch_in = 0; reset_in = 0;
        tick();
        n_tests++;
        if (state_out !== 2'b00) begin
            n_fail++; $display("FAIL halt_exit: got st %b expected 00", state_out);
        end
        reset_in = 1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            reset_in      = ($urandom_range(0, 99) >= 2);
            pc_latch_in   = ($urandom_range(0, 99) < 40);
            pc_ctl_0_in   = 1'($urandom);
            offset_in     = 9'($urandom);
            jmp_in        = ($urandom_range(0, 99) < 20);
            jmp_target_in = 16'($urandom);
            halt_in       = ($urandom_range(0, 99) < 3);
            imem_ready_in = ($urandom_range(0, 99) < 70);
            tick();
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random cycle %0d: got %h expected %h", cyc, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump_priority();
        test_fetch_stall();
        test_wrap_and_reset();
        test_halt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
